// File: rtl/rns_pkg.sv
// Shared definitions for the RNS modulus-13 datapath blocks.
//   MOD13   : channel modulus
//   RES_W   : residue width in bits
//   state_t : accumulator controller states
package rns_pkg;

  localparam int unsigned MOD13 = 13;
  localparam int unsigned RES_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/add_mod_13.sv
// Combinational modulo-13 adder: y = (a + b) mod 13.
// Both operands are expected in 0..12. The sum is formed at RES_W+1 bits, and
// a single conditional subtraction of 13 brings it back into range.
//   a, b : input residues  [RES_W-1:0]
//   y    : output residue  [RES_W-1:0]
module add_mod_13
  import rns_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] y
);

  logic [RES_W:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (RES_W + 1)'(MOD13)) begin
      y = RES_W'(sum - (RES_W + 1)'(MOD13));
    end else begin
      y = sum[RES_W-1:0];
    end
  end

endmodule

// File: rtl/rns_acc_mod_13.sv
// Streaming mod-13 accumulator. It sums `len` residues received over a
// valid/ready input stream and presents the result on a valid/ready output.
//
// Optional feature: when the macro RNS_ACC_RANGE_CHECK_EN is defined, input
// residues 13..15 are folded by subtracting 13, and the sticky err flag is
// raised. Without the macro, inputs pass through unreduced and err stays 0.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, len          : job request and beat count (sampled in IDLE)
//   in_valid/in_ready   : input residue handshake, in_res the residue
//   out_valid/out_ready : result handshake, out_res the mod-13 sum
//   busy                : controller not IDLE
//   err                 : out-of-range residue seen in current/last job
//
// state | meaning
// IDLE  | waiting for start; out_res keeps the last result
// ACCUM | accepting beats; counter holds the beats still to come
// DONE  | result valid; held until out_ready
module rns_acc_mod_13
  import rns_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  output logic             busy,
  output logic             err
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;

  logic             range_hit;
  logic [RES_W-1:0] res_eff;
  logic [RES_W-1:0] acc_sum;

`ifdef RNS_ACC_RANGE_CHECK_EN
  // 13..15 fold to 0..2 with one subtraction, so the adder always sees 0..12.
  assign range_hit = (in_res >= RES_W'(MOD13));
  assign res_eff   = range_hit ? RES_W'(in_res - RES_W'(MOD13)) : in_res;
`else
  assign range_hit = 1'b0;
  assign res_eff   = in_res;
`endif

  add_mod_13 u_add (
    .a (acc_q),
    .b (res_eff),
    .y (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone marks a transfer.
        if (in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q - 1'b1;
          if (range_hit) begin
            err_d = 1'b1;
          end
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_res   = acc_q;
  assign err       = err_q;

endmodule
